// File: rtl/spi_pkg.sv
// Shared constants for the clk-sampled SPI parameter receiver: frame sizes,
// command codes and the bit layout of a 96-bit parameter frame.
package spi_pkg;

  localparam int unsigned FRAME_BITS = 96;
  localparam int unsigned CMD_BITS   = 8;
  localparam int unsigned CNT_BITS   = 7;

  localparam logic [CNT_BITS-1:0] CNT_MAX   = 7'd127;
  localparam logic [CNT_BITS-1:0] FRAME_CNT = 7'(FRAME_BITS);
  localparam logic [CNT_BITS-1:0] CMD_CNT   = 7'(CMD_BITS);

  localparam logic [CMD_BITS-1:0] CMD_TRIG   = 8'h01;
  localparam logic [CMD_BITS-1:0] CMD_MUTE   = 8'h02;
  localparam logic [CMD_BITS-1:0] CMD_UNMUTE = 8'h03;

  localparam int unsigned ADSR_W = 8;
  localparam int unsigned OSC_W  = 32;
  localparam int unsigned FILT_W = 16;

  // LSB position of each field inside the shadow register
  localparam int unsigned AI_LSB  = 88;
  localparam int unsigned DI_LSB  = 80;
  localparam int unsigned S_LSB   = 72;
  localparam int unsigned RI_LSB  = 64;
  localparam int unsigned OSC_LSB = 32;
  localparam int unsigned FA_LSB  = 16;
  localparam int unsigned FB_LSB  = 0;

endpackage

// File: rtl/spi.sv
// SPI-style parameter receiver clocked by the system clock: shifts mosi while
// nss is low and commits a 96-bit parameter frame or an 8-bit command at nss rise.
module spi
  import spi_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                nss,
  input  logic                mosi,
  output logic [ADSR_W-1:0]   adsr_ai,
  output logic [ADSR_W-1:0]   adsr_di,
  output logic [ADSR_W-1:0]   adsr_s,
  output logic [ADSR_W-1:0]   adsr_ri,
  output logic [OSC_W-1:0]    osc_count,
  output logic [FILT_W-1:0]   filter_a,
  output logic [FILT_W-1:0]   filter_b,
  output logic                mute,
  output logic                trig
);

  logic                  nss_prev_q, nss_prev_d;
  logic                  armed_q,    armed_d;
  logic [FRAME_BITS-1:0] shadow_q,   shadow_d;
  logic [CNT_BITS-1:0]   cnt_q,      cnt_d;
  logic [ADSR_W-1:0]     adsr_ai_q,  adsr_ai_d;
  logic [ADSR_W-1:0]     adsr_di_q,  adsr_di_d;
  logic [ADSR_W-1:0]     adsr_s_q,   adsr_s_d;
  logic [ADSR_W-1:0]     adsr_ri_q,  adsr_ri_d;
  logic [OSC_W-1:0]      osc_count_q, osc_count_d;
  logic [FILT_W-1:0]     filter_a_q, filter_a_d;
  logic [FILT_W-1:0]     filter_b_q, filter_b_d;
  logic                  mute_q,     mute_d;
  logic                  trig_q,     trig_d;
  logic                  frame_end;

  // armed stays low after reset until nss is seen high, so a frame cut by reset is dropped
  assign frame_end = nss & ~nss_prev_q & armed_q;

  always_comb begin
    nss_prev_d  = nss;
    armed_d     = armed_q | nss;
    shadow_d    = shadow_q;
    cnt_d       = cnt_q;
    adsr_ai_d   = adsr_ai_q;
    adsr_di_d   = adsr_di_q;
    adsr_s_d    = adsr_s_q;
    adsr_ri_d   = adsr_ri_q;
    osc_count_d = osc_count_q;
    filter_a_d  = filter_a_q;
    filter_b_d  = filter_b_q;
    mute_d      = mute_q;
    trig_d      = 1'b0;

    if (nss) begin
      cnt_d = '0;
    end else if (armed_q) begin
      shadow_d = {shadow_q[FRAME_BITS-2:0], mosi};
      cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 7'd1;
    end

    // decode uses the count and shadow as they stood before this edge
    if (frame_end) begin
      if (cnt_q == FRAME_CNT) begin
        adsr_ai_d   = shadow_q[AI_LSB  +: ADSR_W];
        adsr_di_d   = shadow_q[DI_LSB  +: ADSR_W];
        adsr_s_d    = shadow_q[S_LSB   +: ADSR_W];
        adsr_ri_d   = shadow_q[RI_LSB  +: ADSR_W];
        osc_count_d = shadow_q[OSC_LSB +: OSC_W];
        filter_a_d  = shadow_q[FA_LSB  +: FILT_W];
        filter_b_d  = shadow_q[FB_LSB  +: FILT_W];
      end else if (cnt_q == CMD_CNT) begin
        case (shadow_q[CMD_BITS-1:0])
          CMD_TRIG:   trig_d = 1'b1;
          CMD_MUTE:   mute_d = 1'b1;
          CMD_UNMUTE: mute_d = 1'b0;
          default:    ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nss_prev_q  <= 1'b1;
      armed_q     <= 1'b0;
      shadow_q    <= '0;
      cnt_q       <= '0;
      adsr_ai_q   <= '0;
      adsr_di_q   <= '0;
      adsr_s_q    <= '0;
      adsr_ri_q   <= '0;
      osc_count_q <= '0;
      filter_a_q  <= '0;
      filter_b_q  <= '0;
      mute_q      <= 1'b1;
      trig_q      <= 1'b0;
    end else begin
      nss_prev_q  <= nss_prev_d;
      armed_q     <= armed_d;
      shadow_q    <= shadow_d;
      cnt_q       <= cnt_d;
      adsr_ai_q   <= adsr_ai_d;
      adsr_di_q   <= adsr_di_d;
      adsr_s_q    <= adsr_s_d;
      adsr_ri_q   <= adsr_ri_d;
      osc_count_q <= osc_count_d;
      filter_a_q  <= filter_a_d;
      filter_b_q  <= filter_b_d;
      mute_q      <= mute_d;
      trig_q      <= trig_d;
    end
  end

  assign adsr_ai   = adsr_ai_q;
  assign adsr_di   = adsr_di_q;
  assign adsr_s    = adsr_s_q;
  assign adsr_ri   = adsr_ri_q;
  assign osc_count = osc_count_q;
  assign filter_a  = filter_a_q;
  assign filter_b  = filter_b_q;
  assign mute      = mute_q;
  assign trig      = trig_q;

endmodule

// File: tb/tb_spi.sv
// Scoreboard bench for spi: the driver pushes the expected output state with the
// cycle it must appear on; the monitor compares every cycle against the latest state.
module tb_spi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        nss = 1'b1;
  logic        mosi = 1'b0;
  logic [7:0]  adsr_ai, adsr_di, adsr_s, adsr_ri;
  logic [31:0] osc_count;
  logic [15:0] filter_a, filter_b;
  logic        mute, trig;

  spi dut (
    .clk(clk), .rst_n(rst_n), .nss(nss), .mosi(mosi),
    .adsr_ai(adsr_ai), .adsr_di(adsr_di), .adsr_s(adsr_s), .adsr_ri(adsr_ri),
    .osc_count(osc_count), .filter_a(filter_a), .filter_b(filter_b),
    .mute(mute), .trig(trig)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  ai, di, s, ri;
    logic [31:0] osc;
    logic [15:0] fa, fb;
    logic        mute, trig;
  } exp_t;

  typedef struct {
    int unsigned cyc;
    exp_t        e;
  } ent_t;

  ent_t        sb_q[$];
  exp_t        model;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  function automatic exp_t reset_exp();
    exp_t r;
    r = '0;
    r.mute = 1'b1;
    return r;
  endfunction

  function automatic void push_exp(input exp_t e, input int unsigned at);
    ent_t t;
    t.cyc = at;
    t.e   = e;
    sb_q.push_back(t);
  endfunction

  // Reference: what a frame of n bits (MSB first, last bit in d[0]) does to the outputs
  function automatic void model_frame_end(input logic [255:0] d, input int n);
    exp_t e;
    e = model;
    e.trig = 1'b0;
    if (n == 96) begin
      e.ai  = d[95:88];
      e.di  = d[87:80];
      e.s   = d[79:72];
      e.ri  = d[71:64];
      e.osc = d[63:32];
      e.fa  = d[31:16];
      e.fb  = d[15:0];
    end else if (n == 8) begin
      if (d[7:0] == 8'h01) e.trig = 1'b1;
      else if (d[7:0] == 8'h02) e.mute = 1'b1;
      else if (d[7:0] == 8'h03) e.mute = 1'b0;
    end
    push_exp(e, cyc + 1);
    if (e.trig) begin
      e.trig = 1'b0;
      push_exp(e, cyc + 2);
    end
    model = e;
  endfunction

  // Monitor: one whole-output comparison per cycle, just after the rising edge
  initial begin : monitor
    exp_t cur;
    exp_t act;
    ent_t t;
    cur = reset_exp();
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        t   = sb_q.pop_front();
        cur = t.e;
      end
      act = {adsr_ai, adsr_di, adsr_s, adsr_ri, osc_count, filter_a, filter_b, mute, trig};
      n_checks++;
      if (act === cur) n_pass++;
      else $display("FAIL outputs cyc=%0d actual=%h required=%h", cyc, act, cur);
    end
  end

  task automatic shift_bits(input logic [255:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      nss  = 1'b0;
      mosi = d[n-1-i];
    end
  endtask

  task automatic send_frame(input logic [255:0] d, input int n, input int gap);
    shift_bits(d, n);
    @(negedge clk);
    nss  = 1'b1;
    mosi = 1'b0;
    model_frame_end(d, n);
    repeat (gap) @(negedge clk);
  endtask

  function automatic logic [255:0] rand_data();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  initial begin : driver
    logic [255:0] d;
    int           kind;
    int           n;
    model = reset_exp();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // known register frame, then unmute and trigger commands
    d = '0;
    d[95:0] = 96'h123456789ABCDEF012345678;
    send_frame(d, 96, 2);
    d = '0; d[7:0] = 8'h03; send_frame(d, 8, 2);
    d = '0; d[7:0] = 8'h01; send_frame(d, 8, 3);

    // near-miss lengths and a length that would alias to 96 if the counter wrapped
    send_frame(rand_data(), 95, 2);
    send_frame(rand_data(), 97, 2);
    send_frame(rand_data(), 224, 2);
    send_frame(rand_data(), 7, 1);
    send_frame(rand_data(), 9, 1);

    // reset in the middle of a frame; nss stays low and the rest must not commit
    shift_bits(rand_data(), 40);
    @(negedge clk);
    rst_n = 1'b0;
    mosi  = 1'b1;
    model = reset_exp();
    push_exp(model, cyc + 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    shift_bits(rand_data(), 95);
    @(negedge clk);
    nss  = 1'b1;
    mosi = 1'b0;
    repeat (4) @(negedge clk);

    // back-to-back frames with a single idle cycle, second one all ones
    send_frame(rand_data(), 96, 0);
    d = '1;
    send_frame(d, 96, 2);

    // randomized traffic
    for (int k = 0; k < 200; k++) begin
      kind = $urandom_range(0, 3);
      d = rand_data();
      if (kind == 0) begin
        n = 96;
      end else if (kind == 1) begin
        n = 8;
        d[7:0] = 8'($urandom_range(0, 5));
      end else begin
        n = $urandom_range(1, 140);
        if (n == 8 || n == 96) n = n + 1;
      end
      send_frame(d, n, $urandom_range(0, 3));
    end

    repeat (5) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain actual=%0d entries required=0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi.md
SPI -- requirements
Module: spi

Interface
REQ-001 Parameters: none; frame width fixed at 96 bits, command width fixed at 8 bits.
REQ-002 One clock; reset is asynchronous and active-low; ports named clk and rst_n.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 nss  input  1  active-low frame select, synchronous to clk, no synchronizer.
REQ-006 mosi  input  1  serial data, MSB first, synchronous to clk, no synchronizer.
REQ-007 adsr_ai  output  8  attack increment.
REQ-008 adsr_di  output  8  decay increment.
REQ-009 adsr_s  output  8  sustain level.
REQ-010 adsr_ri  output  8  release increment.
REQ-011 osc_count  output  32  oscillator period count.
REQ-012 filter_a  output  16  filter coefficient A.
REQ-013 filter_b  output  16  filter coefficient B.
REQ-014 mute  output  1  audio mute flag.
REQ-015 trig  output  1  one-cycle note trigger pulse.

Function
REQ-016 No separate serial clock; mosi is sampled once per clk rising edge while sampled nss = 0; one bit per cycle.
REQ-017 Received bits shift into a 96-bit shadow register from LSB, left-shifting, so the first bit ends at bit 95 after 96 bits.
REQ-018 A 7-bit bit counter clears when nss = 1, increments per sampled bit, and saturates at 127.
REQ-019 Frame end = sampled nss 1 with previous sampled nss 0; all decode happens only at frame end.
REQ-020 Count = 96 at frame end: outputs load from shadow: adsr_ai=[95:88], adsr_di=[87:80], adsr_s=[79:72], adsr_ri=[71:64], osc_count=[63:32], filter_a=[31:16], filter_b=[15:0].
REQ-021 Count = 8 at frame end: shadow[7:0] is a command: 0x01 pulse trig, 0x02 mute=1, 0x03 mute=0; other values ignored.
REQ-022 Any other count (including 0 and >96) at frame end: frame discarded, no output change.
REQ-023 Outputs change on the clk edge that samples the nss rising edge; latency one cycle after nss goes high; all outputs held stable between commits.
REQ-024 trig is high exactly one clk cycle per valid 0x01 command, never otherwise.
REQ-025 Register frames leave mute and trig unaffected; commands leave the parameter outputs unaffected.
REQ-026 nss low for a new frame on the cycle right after frame end starts a fresh count from 0.

Reset
REQ-027 rst_n low: all parameter outputs = 0, trig = 0, mute = 1, shadow = 0, counter = 0, nss history = 1.
REQ-028 Reset mid-frame aborts the frame; after release the partial frame is not committed; only a subsequent nss fall starts reception.

Structure
REQ-029 Shared package: FRAME_BITS=96, CMD_BITS=8, command codes CMD_TRIG=0x01, CMD_MUTE=0x02, CMD_UNMUTE=0x03, and field bit positions.
REQ-030 Single flat module; no sub-module; all outputs registered.

Verification
REQ-031 Reset, no frame -> all parameter outputs 0, mute=1, trig=0.
REQ-032 96-bit frame 0x123456789ABCDEF012345678 -> adsr_ai=0x12, adsr_di=0x34, adsr_s=0x56, adsr_ri=0x78, osc_count=0x9ABCDEF0, filter_a=0x1234, filter_b=0x5678, one cycle after nss rises; mute still 1.
REQ-033 8-bit frame 0x03, then 0x01 -> mute=0, then trig high exactly one cycle; parameters unchanged.
REQ-034 95-bit and 97-bit frames after a valid frame -> outputs keep previous values.
REQ-035 rst_n pulsed low after 40 bits of a frame -> reset values; nss raised later -> no commit.
REQ-036 Back-to-back 96-bit frames with one idle cycle, second 0xFF..FF -> all parameter fields all-ones after second frame.
